// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-unit boundary: instruction bus, redirect/interrupt inputs and the decode-side queue head.
interface fetch_prefetch_queue_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              ireq_valid;
   logic [ADDR_W-1:0] ireq_addr;
   logic              iresp_addr_ok;
   logic              iresp_data_ok;
   logic [INST_W-1:0] iresp_data;
   logic              redir_valid;
   logic [ADDR_W-1:0] redir_pc;
   logic              int_valid;
   logic [3:0]        int_code;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic              out_trap_valid;
   logic [3:0]        out_trap_code;
   logic [ADDR_W-1:0] fetch_pc;

   modport master (
      output ireq_valid, ireq_addr,
      input  iresp_addr_ok, iresp_data_ok, iresp_data,
      input  redir_valid, redir_pc, int_valid, int_code,
      output out_valid, out_inst, out_pc, out_trap_valid, out_trap_code, fetch_pc,
      input  out_ready
   );

   modport slave (
      input  ireq_valid, ireq_addr,
      output iresp_addr_ok, iresp_data_ok, iresp_data,
      output redir_valid, redir_pc, int_valid, int_code,
      input  out_valid, out_inst, out_pc, out_trap_valid, out_trap_code, fetch_pc,
      output out_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Decoupled fetch: one outstanding bus request feeding a DEPTH-entry instruction queue,
// with redirect flush and fetch-side trap injection (misaligned PC, interrupt).
module fetch_prefetch_queue #(
   parameter int                ADDR_W  = 64,
   parameter int                INST_W  = 32,
   parameter int                DEPTH   = 4,
   parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(64'h8000_0000)
) (
   input logic                    clk,
   input logic                    rst_n,
   fetch_prefetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
   logic [ADDR_W-1:0] ireq_addr, ireq_addr_nx;
   logic              ireq_valid, ireq_valid_nx;

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [INST_W-1:0] q_inst [DEPTH];
   logic [ADDR_W-1:0] q_pc   [DEPTH];
   logic              q_trap [DEPTH];
   logic [3:0]        q_code [DEPTH];

   logic              resp, inflight, credit, flush, enq, deq, head_valid;
   logic [INST_W-1:0] enq_inst;
   logic [ADDR_W-1:0] enq_pc;
   logic              enq_trap;
   logic [3:0]        enq_code;

   assign resp       = bus.iresp_addr_ok & bus.iresp_data_ok;
   assign inflight   = (state == WAIT) || (state == DRAIN);
   assign credit     = (count + CNT_W'(inflight)) < CNT_W'(DEPTH);
   assign head_valid = (count != '0);
   assign deq        = head_valid & bus.out_ready;

   always_comb begin
      state_nx      = state;
      fetch_pc_nx   = fetch_pc;
      ireq_valid_nx = ireq_valid;
      ireq_addr_nx  = ireq_addr;
      flush         = 1'b0;
      enq           = 1'b0;
      enq_inst      = '0;
      enq_pc        = fetch_pc;
      enq_trap      = 1'b0;
      enq_code      = '0;

      if (bus.redir_valid) begin
         // Redirect wins everywhere; an in-flight request must still be drained off the bus.
         flush       = 1'b1;
         fetch_pc_nx = bus.redir_pc;
         case (state)
            WAIT, DRAIN: begin
               if (resp) begin
                  ireq_valid_nx = 1'b0;
                  state_nx      = IDLE;
               end else begin
                  state_nx = DRAIN;
               end
            end
            default: state_nx = IDLE;
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (credit) begin
                  if (bus.int_valid) begin
                     enq      = 1'b1;
                     enq_trap = 1'b1;
                     enq_code = bus.int_code;
                     state_nx = HALT;
                  end else if (fetch_pc[1:0] != 2'b00) begin
                     enq      = 1'b1;
                     enq_trap = 1'b1;
                     state_nx = HALT;
                  end else begin
                     ireq_valid_nx = 1'b1;
                     ireq_addr_nx  = fetch_pc;
                     state_nx      = WAIT;
                  end
               end
            end
            WAIT: begin
               if (resp) begin
                  enq           = 1'b1;
                  enq_inst      = bus.iresp_data;
                  enq_pc        = ireq_addr;
                  ireq_valid_nx = 1'b0;
                  fetch_pc_nx   = fetch_pc + ADDR_W'(4);
                  state_nx      = IDLE;
               end
            end
            DRAIN: begin
               if (resp) begin
                  ireq_valid_nx = 1'b0;
                  state_nx      = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fetch_pc   <= PC_INIT;
         ireq_valid <= 1'b0;
         ireq_addr  <= '0;
      end else begin
         state      <= state_nx;
         fetch_pc   <= fetch_pc_nx;
         ireq_valid <= ireq_valid_nx;
         ireq_addr  <= ireq_addr_nx;
      end
   end

   // Queue bookkeeping: flush beats enqueue; simultaneous enq/deq leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_inst[wr_ptr] <= enq_inst;
         q_pc[wr_ptr]   <= enq_pc;
         q_trap[wr_ptr] <= enq_trap;
         q_code[wr_ptr] <= enq_code;
      end
   end

   // Head fields read as zero while empty, so reset and flush never expose stale entries.
   assign bus.out_valid      = head_valid;
   assign bus.out_inst       = head_valid ? q_inst[rd_ptr] : '0;
   assign bus.out_pc         = head_valid ? q_pc[rd_ptr]   : '0;
   assign bus.out_trap_valid = head_valid ? q_trap[rd_ptr] : 1'b0;
   assign bus.out_trap_code  = head_valid ? q_code[rd_ptr] : '0;
   assign bus.ireq_valid     = ireq_valid;
   assign bus.ireq_addr      = ireq_addr;
   assign bus.fetch_pc       = fetch_pc;
endmodule
